ifetch_dmem_sram_arbiter: RTL and testbench



---
 rtl/ifetch_dmem_sram_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_ifetch_dmem_sram_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_dmem_sram_arbiter.sv
// ============================================================================
// Module      : ifetch_dmem_sram_arbiter
// Description : Shares one asynchronous single-port SRAM between the
//               instruction-fetch port and the data-memory port. Sequences
//               the SRAM strobes with programmable wait states, returns read
//               data with a one-cycle finish pulse and raises pipeline stalls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ifetch_dmem_sram_arbiter #(
  parameter int ADDR_W  = 20,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction fetch port
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [31:0]       o_if_rdata,
  output logic              o_if_fin,
  output logic              o_stall_if,
  // data memory port
  input  logic              i_dm_req,
  input  logic              i_dm_we,
  input  logic [3:0]        i_dm_be,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [31:0]       i_dm_wdata,
  output logic [31:0]       o_dm_rdata,
  output logic              o_dm_fin,
  output logic              o_stall_mem,
  // SRAM side
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [31:0]       o_ram_wdata,
  output logic              o_ram_dq_oe,
  input  logic [31:0]       i_ram_rdata,
  output logic              o_ram_ce_n,
  output logic              o_ram_oe_n,
  output logic              o_ram_we_n,
  output logic [3:0]        o_ram_be_n
);

  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_IRD     = 3'd1;
  localparam logic [2:0] S_DRD     = 3'd2;
  localparam logic [2:0] S_DWR     = 3'd3;
  localparam logic [2:0] S_DWR_REC = 3'd4;

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last_dm;   // 1 = last grant went to data, 0 = fetch
  logic [ADDR_W-1:0] r_ram_addr;
  logic [31:0]       r_ram_wdata;
  logic              r_ram_dq_oe;
  logic              r_ram_ce_n;
  logic              r_ram_oe_n;
  logic              r_ram_we_n;
  logic [3:0]        r_ram_be_n;
  logic [31:0]       r_if_rdata;
  logic [31:0]       r_dm_rdata;
  logic              r_if_fin;
  logic              r_dm_fin;

  logic              w_pick_dm;
  logic              w_pick_if;

  // On a tie the port that did not win last time is served.
  assign w_pick_dm = i_dm_req & (~i_if_req | ~r_last_dm);
  assign w_pick_if = i_if_req & ~w_pick_dm;

  // Arbitration, strobe sequencing and read-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_last_dm   <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_dq_oe <= 1'b0;
      r_ram_ce_n  <= 1'b1;
      r_ram_oe_n  <= 1'b1;
      r_ram_we_n  <= 1'b1;
      r_ram_be_n  <= 4'hF;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_fin    <= 1'b0;
      r_dm_fin    <= 1'b0;
    end else begin
      r_if_fin <= 1'b0;
      r_dm_fin <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_dm) begin
            r_last_dm  <= 1'b1;
            r_ram_addr <= i_dm_addr;
            r_ram_ce_n <= 1'b0;
            if (i_dm_we) begin
              r_state     <= S_DWR;
              r_cnt       <= WR_LOAD;
              r_ram_wdata <= i_dm_wdata;
              r_ram_be_n  <= ~i_dm_be;
              r_ram_we_n  <= ~(|i_dm_be);  // empty byte mask: keep we_n high
              r_ram_dq_oe <= 1'b1;
            end else begin
              r_state    <= S_DRD;
              r_cnt      <= RD_LOAD;
              r_ram_be_n <= 4'h0;
              r_ram_oe_n <= 1'b0;
            end
          end else if (w_pick_if) begin
            r_last_dm  <= 1'b0;
            r_state    <= S_IRD;
            r_cnt      <= RD_LOAD;
            r_ram_addr <= i_if_addr;
            r_ram_ce_n <= 1'b0;
            r_ram_oe_n <= 1'b0;
            r_ram_be_n <= 4'h0;
          end
        end
        S_IRD, S_DRD: begin
          if (r_cnt == '0) begin
            if (r_state == S_IRD) begin
              r_if_rdata <= i_ram_rdata;
              r_if_fin   <= 1'b1;
            end else begin
              r_dm_rdata <= i_ram_rdata;
              r_dm_fin   <= 1'b1;
            end
            r_state    <= S_IDLE;
            r_ram_ce_n <= 1'b1;
            r_ram_oe_n <= 1'b1;
            r_ram_be_n <= 4'hF;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DWR: begin
          if (r_cnt == '0) begin
            // release we_n first, keep address/data driven for hold time
            r_state    <= S_DWR_REC;
            r_ram_we_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DWR_REC: begin
          r_state     <= S_IDLE;
          r_ram_ce_n  <= 1'b1;
          r_ram_dq_oe <= 1'b0;
          r_ram_be_n  <= 4'hF;
          r_dm_fin    <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_ram_ce_n  <= 1'b1;
          r_ram_oe_n  <= 1'b1;
          r_ram_we_n  <= 1'b1;
          r_ram_dq_oe <= 1'b0;
          r_ram_be_n  <= 4'hF;
        end
      endcase
    end
  end

  assign o_stall_if  = i_if_req & ~r_if_fin;
  assign o_stall_mem = i_dm_req & ~r_dm_fin;

  assign o_if_rdata  = r_if_rdata;
  assign o_if_fin    = r_if_fin;
  assign o_dm_rdata  = r_dm_rdata;
  assign o_dm_fin    = r_dm_fin;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_wdata = r_ram_wdata;
  assign o_ram_dq_oe = r_ram_dq_oe;
  assign o_ram_ce_n  = r_ram_ce_n;
  assign o_ram_oe_n  = r_ram_oe_n;
  assign o_ram_we_n  = r_ram_we_n;
  assign o_ram_be_n  = r_ram_be_n;

endmodule

`default_nettype wire

// File: tb/tb_ifetch_dmem_sram_arbiter.sv
// ============================================================================
// Module      : tb_ifetch_dmem_sram_arbiter
// Description : Scoreboard bench for ifetch_dmem_sram_arbiter with a simple
//               byte-maskable SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ifetch_dmem_sram_arbiter;

  typedef struct packed {
    logic        wr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        i_if_req;
  logic [19:0] i_if_addr;
  logic [31:0] o_if_rdata;
  logic        o_if_fin;
  logic        o_stall_if;
  logic        i_dm_req;
  logic        i_dm_we;
  logic [3:0]  i_dm_be;
  logic [19:0] i_dm_addr;
  logic [31:0] i_dm_wdata;
  logic [31:0] o_dm_rdata;
  logic        o_dm_fin;
  logic        o_stall_mem;
  logic [19:0] o_ram_addr;
  logic [31:0] o_ram_wdata;
  logic        o_ram_dq_oe;
  logic [31:0] w_ram_rdata;
  logic        o_ram_ce_n;
  logic        o_ram_oe_n;
  logic        o_ram_we_n;
  logic [3:0]  o_ram_be_n;

  ifetch_dmem_sram_arbiter #(.ADDR_W(20), .RD_WAIT(1), .WR_WAIT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_rdata(o_if_rdata),
    .o_if_fin(o_if_fin), .o_stall_if(o_stall_if),
    .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_be(i_dm_be),
    .i_dm_addr(i_dm_addr), .i_dm_wdata(i_dm_wdata), .o_dm_rdata(o_dm_rdata),
    .o_dm_fin(o_dm_fin), .o_stall_mem(o_stall_mem),
    .o_ram_addr(o_ram_addr), .o_ram_wdata(o_ram_wdata), .o_ram_dq_oe(o_ram_dq_oe),
    .i_ram_rdata(w_ram_rdata), .o_ram_ce_n(o_ram_ce_n), .o_ram_oe_n(o_ram_oe_n),
    .o_ram_we_n(o_ram_we_n), .o_ram_be_n(o_ram_be_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t q_if[$];
  exp_t q_dm[$];
  exp_t e_if, e_dm;

  // Running tallies sampled by the monitor; tests take differences.
  int         cnt_stall_if = 0;
  int         cnt_oe = 0;
  int         cnt_we = 0;
  int         cnt_dq = 0;
  int         cnt_dmfin = 0;
  logic [3:0] last_we_be_n = 4'hF;

  // SRAM model: 256 words indexed by the low address byte.
  logic [31:0] mem [256];
  bit          mem_init = 1'b0;

  assign w_ram_rdata = (!o_ram_ce_n && !o_ram_oe_n) ? mem[o_ram_addr[7:0]] : 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h10] <= 32'h3C011234;
      mem[8'h20] <= 32'h11223344;
      mem[8'h21] <= 32'hCAFEF00D;
      mem[8'h30] <= 32'h0BADF00D;
      mem[8'h40] <= 32'hA0000040;
      mem[8'h41] <= 32'hA0000041;
      mem[8'h50] <= 32'hB0000050;
      mem[8'h51] <= 32'hB0000051;
      mem[8'h60] <= 32'h00000060;
      mem[8'hA5] <= 32'h5A5AC3C3;
      mem_init   <= 1'b1;
    end else if (!o_ram_ce_n && !o_ram_we_n) begin
      for (int b = 0; b < 4; b++)
        if (!o_ram_be_n[b]) mem[o_ram_addr[7:0]][8*b +: 8] <= o_ram_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: protocol checks every cycle, scoreboard pops on each fin pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("oe_we_overlap", 64'(!o_ram_oe_n && !o_ram_we_n), 64'd0);
      chk("dq_oe_during_read", 64'(o_ram_dq_oe && !o_ram_oe_n), 64'd0);
      if (o_if_fin) begin
        if (q_if.size() == 0) chk("if_fin_unexpected", 64'd1, 64'd0);
        else begin
          e_if = q_if.pop_front();
          chk("if_fin_cycle", 64'(cyc), 64'(e_if.cyc));
          chk("if_rdata", 64'(o_if_rdata), 64'(e_if.data));
        end
      end
      if (o_dm_fin) begin
        if (q_dm.size() == 0) chk("dm_fin_unexpected", 64'd1, 64'd0);
        else begin
          e_dm = q_dm.pop_front();
          chk("dm_fin_cycle", 64'(cyc), 64'(e_dm.cyc));
          if (!e_dm.wr) chk("dm_rdata", 64'(o_dm_rdata), 64'(e_dm.data));
        end
      end
    end
    if (o_stall_if) cnt_stall_if <= cnt_stall_if + 1;
    if (!o_ram_oe_n) cnt_oe <= cnt_oe + 1;
    if (!o_ram_we_n) begin
      cnt_we       <= cnt_we + 1;
      last_we_be_n <= o_ram_be_n;
    end
    if (o_ram_dq_oe) cnt_dq <= cnt_dq + 1;
    if (o_dm_fin) cnt_dmfin <= cnt_dmfin + 1;
  end

  task automatic if_rd(input logic [19:0] a, input logic [31:0] d, input int ec, input bit keep);
    bit done = 1'b0;
    i_if_req  = 1'b1;
    i_if_addr = a;
    q_if.push_back('{wr: 1'b0, data: d, cyc: ec});
    for (int k = 0; k < 20 && !done; k++) begin
      @(posedge clk); #1;
      done = o_if_fin;
    end
    if (!done) chk("if_timeout", 64'd1, 64'd0);
    if (!keep) i_if_req = 1'b0;
  endtask

  task automatic dm_go(input bit we, input logic [3:0] be, input logic [19:0] a,
                       input logic [31:0] wd, input logic [31:0] d, input int ec, input bit keep);
    bit done = 1'b0;
    i_dm_req   = 1'b1;
    i_dm_we    = we;
    i_dm_be    = be;
    i_dm_addr  = a;
    i_dm_wdata = wd;
    q_dm.push_back('{wr: we, data: d, cyc: ec});
    for (int k = 0; k < 20 && !done; k++) begin
      @(posedge clk); #1;
      done = o_dm_fin;
    end
    if (!done) chk("dm_timeout", 64'd1, 64'd0);
    if (!keep) i_dm_req = 1'b0;
  endtask

  int base, s0, s1, s2, s3;

  initial begin
    rst_n = 1'b0;
    i_if_req = 1'b0; i_if_addr = '0;
    i_dm_req = 1'b0; i_dm_we = 1'b0; i_dm_be = 4'h0; i_dm_addr = '0; i_dm_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_strobes", 64'({o_ram_ce_n, o_ram_oe_n, o_ram_we_n, o_ram_be_n, o_ram_dq_oe}), 64'hFE);
    chk("reset_addr", 64'(o_ram_addr), 64'd0);
    chk("reset_wdata", 64'(o_ram_wdata), 64'd0);
    chk("reset_rdata", 64'({o_if_rdata, o_dm_rdata}), 64'd0);
    chk("reset_fin", 64'({o_if_fin, o_dm_fin}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single fetch: 1 read cycle, fin two edges after request is driven.
    @(posedge clk); #1;
    base = cyc; s0 = cnt_stall_if; s1 = cnt_oe;
    if_rd(20'h00010, 32'h3C011234, base + 2, 1'b0);
    @(negedge clk);
    chk("fetch_stall_cycles", 64'(cnt_stall_if - s0), 64'd2);
    chk("fetch_oe_cycles", 64'(cnt_oe - s1), 64'd1);

    // Both ports held high: data wins the first tie, then strict alternation.
    @(posedge clk); #1;
    base = cyc;
    fork
      begin
        dm_go(1'b0, 4'hF, 20'h00040, 32'h0, 32'hA0000040, base + 2, 1'b1);
        dm_go(1'b0, 4'hF, 20'h00041, 32'h0, 32'hA0000041, base + 6, 1'b0);
      end
      begin
        if_rd(20'h00050, 32'hB0000050, base + 4, 1'b1);
        if_rd(20'h00051, 32'hB0000051, base + 8, 1'b0);
      end
    join

    // Partial store: 2 write cycles + 1 recovery, low two bytes only.
    @(posedge clk); #1;
    base = cyc; s0 = cnt_we; s1 = cnt_dq; s2 = cnt_oe;
    dm_go(1'b1, 4'b0011, 20'h00020, 32'hDEADBEEF, 32'h0, base + 4, 1'b0);
    @(negedge clk);
    chk("store_we_cycles", 64'(cnt_we - s0), 64'd2);
    chk("store_dq_oe_cycles", 64'(cnt_dq - s1), 64'd3);
    chk("store_be_n", 64'(last_we_be_n), 64'hC);
    chk("store_oe_cycles", 64'(cnt_oe - s2), 64'd0);
    @(posedge clk); #1;
    base = cyc;
    dm_go(1'b0, 4'hF, 20'h00020, 32'h0, 32'h1122BEEF, base + 2, 1'b0);

    // Load at 0x0A5A5 with a fetch arriving one cycle later.
    @(posedge clk); #1;
    base = cyc;
    fork
      dm_go(1'b0, 4'hF, 20'h0A5A5, 32'h0, 32'h5A5AC3C3, base + 2, 1'b0);
      begin
        @(posedge clk); #1;
        if_rd(20'h00060, 32'h00000060, base + 4, 1'b0);
      end
    join

    // Empty byte mask: no write strobe, same completion time.
    @(posedge clk); #1;
    base = cyc; s0 = cnt_we;
    dm_go(1'b1, 4'b0000, 20'h00021, 32'hFFFFFFFF, 32'h0, base + 4, 1'b0);
    @(negedge clk);
    chk("nobe_we_cycles", 64'(cnt_we - s0), 64'd0);
    @(posedge clk); #1;
    base = cyc;
    dm_go(1'b0, 4'hF, 20'h00021, 32'h0, 32'hCAFEF00D, base + 2, 1'b0);

    // Reset during the first write cycle aborts with no fin.
    @(posedge clk); #1;
    s3 = cnt_dmfin;
    i_dm_req = 1'b1; i_dm_we = 1'b1; i_dm_be = 4'hF;
    i_dm_addr = 20'h00030; i_dm_wdata = 32'h12345678;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_strobes", 64'({o_ram_ce_n, o_ram_oe_n, o_ram_we_n, o_ram_dq_oe}), 64'hE);
    i_dm_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort_no_fin", 64'(cnt_dmfin - s3), 64'd0);
    chk("abort_mem_untouched", 64'(mem[8'h30]), 64'h0BADF00D);
    @(posedge clk); #1;
    base = cyc;
    dm_go(1'b1, 4'hF, 20'h00030, 32'h12345678, 32'h0, base + 4, 1'b0);
    @(posedge clk); #1;
    base = cyc;
    dm_go(1'b0, 4'hF, 20'h00030, 32'h0, 32'h12345678, base + 2, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("if_queue_drained", 64'(q_if.size()), 64'd0);
    chk("dm_queue_drained", 64'(q_dm.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
